// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational 16-bit ALU between two requesters. A winner is
// picked inside the accept window, its operands/control are registered onto
// the ALU input ports, the ALU result and flags are captured one cycle later,
// and the captured result is returned on a valid/ready response channel.
// A condition-code register (ccr) holds the flags of the latest operation.
//
// Optional build macro:
//   ALU_SHARE_FIXED_PRIO_EN  - requester 0 always wins when both are valid
//                              (default: round-robin between the two).
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 3,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,

  // Requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req0_in2,
  input  logic [CTRL_W-1:0] req0_ctrl,

  // Requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [DATA_W-1:0] req1_in2,
  input  logic [CTRL_W-1:0] req1_ctrl,

  // Shared ALU
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flag,

  // Response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [FLAG_W-1:0] rsp_flag,

  // Status
  output logic [FLAG_W-1:0] ccr,
  output logic              busy
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;  // waiting for a request
  localparam logic [1:0] S_EXEC = 2'd1;  // operands on the ALU, result next edge
  localparam logic [1:0] S_RESP = 2'd2;  // response presented, waiting for ready

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic              r_last_grant;   // requester granted most recently
  logic              r_op_id;        // owner of the operation on the ALU

  logic [DATA_W-1:0] r_alu_in1;
  logic [DATA_W-1:0] r_alu_in2;
  logic [CTRL_W-1:0] r_alu_ctrl;

  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic [FLAG_W-1:0] r_rsp_flag;
  logic [FLAG_W-1:0] r_ccr;

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  logic              w_accept_window;  // a new request may be taken this cycle
  logic              w_any_req;
  logic              w_grant_id;       // winner if a request is taken
  logic              w_accept;         // a request is taken on the next edge
  logic [DATA_W-1:0] w_win_in1;
  logic [DATA_W-1:0] w_win_in2;
  logic [CTRL_W-1:0] w_win_ctrl;

  // A new request fits when idle, or when the pending response leaves this
  // very cycle, which gives back-to-back operations every two cycles.
  assign w_accept_window = (r_state == S_IDLE) ||
                           ((r_state == S_RESP) && rsp_ready);
  assign w_any_req       = req0_valid || req1_valid;
  assign w_accept        = w_accept_window && w_any_req;

  // Pick the winner among the valid requesters.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      w_grant_id = 1'b0;
`else
      w_grant_id = ~r_last_grant;
`endif
    end else if (req1_valid) begin
      w_grant_id = 1'b1;
    end
  end

  // Steer the winner's operands and control toward the ALU input registers.
  always_comb begin
    w_win_in1  = req0_in1;
    w_win_in2  = req0_in2;
    w_win_ctrl = req0_ctrl;
    if (w_grant_id) begin
      w_win_in1  = req1_in1;
      w_win_in2  = req1_in2;
      w_win_ctrl = req1_ctrl;
    end
  end

  // Ready goes only to the winner and only inside the accept window, so at
  // most one requester sees ready in any cycle.
  assign req0_ready = w_accept_window && req0_valid && !w_grant_id;
  assign req1_ready = w_accept_window && req1_valid &&  w_grant_id;

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------

  // Control FSM: IDLE -> EXEC -> RESP -> (IDLE | EXEC).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every register samples pre-edge values regardless of block order.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) r_state <= w_accept ? S_EXEC : S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Load the granted request onto the ALU ports and remember its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the ALU operand registers are visible ports, so they are reset
      // to a known zero rather than left to power-up contents.
      r_alu_in1    <= '0;
      r_alu_in2    <= '0;
      r_alu_ctrl   <= '0;
      r_op_id      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_alu_in1    <= w_win_in1;
      r_alu_in2    <= w_win_in2;
      r_alu_ctrl   <= w_win_ctrl;
      r_op_id      <= w_grant_id;
      r_last_grant <= w_grant_id;
    end
  end

  // Capture the ALU result and flags at the end of EXEC; hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_rsp_flag <= '0;
      r_rsp_id   <= 1'b0;
      r_ccr      <= '0;
    end else if (r_state == S_EXEC) begin
      r_rsp_data <= alu_out;
      r_rsp_flag <= alu_flag;
      r_rsp_id   <= r_op_id;
      r_ccr      <= alu_flag;
    end
  end

  // Response valid: raised by the capture, dropped when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_rsp_valid <= 1'b1;
    end else if ((r_state == S_RESP) && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign alu_in1   = r_alu_in1;
  assign alu_in2   = r_alu_in2;
  assign alu_ctrl  = r_alu_ctrl;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_flag  = r_rsp_flag;
  assign ccr       = r_ccr;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed bench for alu_share_arbiter with an ALU stub
// (ctrl==000: in1+in2, else in1&in2; flag = {out[15], carry, out==0}).
// Expected responses are queued when a request is driven and compared when
// the response handshake completes. Define ALU_SHARE_FIXED_PRIO_EN for both
// the design and this bench to exercise the fixed-priority build.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int DW = 16;
  localparam int CW = 3;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready;
  logic [DW-1:0] req0_in1, req0_in2;
  logic [CW-1:0] req0_ctrl;
  logic          req1_valid, req1_ready;
  logic [DW-1:0] req1_in1, req1_in2;
  logic [CW-1:0] req1_ctrl;
  logic [DW-1:0] alu_in1, alu_in2, alu_out;
  logic [CW-1:0] alu_ctrl;
  logic [FW-1:0] alu_flag;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0] rsp_data;
  logic [FW-1:0] rsp_flag, ccr;
  logic          busy;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    logic [FW-1:0] flag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW), .FLAG_W(FW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .req1_ctrl  (req1_ctrl),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_ctrl   (alu_ctrl),
    .alu_out    (alu_out),
    .alu_flag   (alu_flag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_flag   (rsp_flag),
    .ccr        (ccr),
    .busy       (busy)
  );

  // ALU behaviour: returns {flag, out}.
  function automatic logic [FW+DW-1:0] alu_model(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b,
                                                 input logic [CW-1:0] c);
    logic [DW:0]   s;
    logic [DW-1:0] o;
    logic          cy;
    if (c == 3'b000) begin
      s  = {1'b0, a} + {1'b0, b};
      o  = s[DW-1:0];
      cy = s[DW];
    end else begin
      o  = a & b;
      cy = 1'b0;
    end
    return {o[DW-1], cy, (o == '0), o};
  endfunction

  assign {alu_flag, alu_out} = alu_model(alu_in1, alu_in2, alu_ctrl);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic id, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [CW-1:0] c);
    logic [FW+DW-1:0] r;
    exp_t e;
    r      = alu_model(a, b, c);
    e.id   = id;
    e.data = r[DW-1:0];
    e.flag = r[FW+DW-1:DW];
    sb.push_back(e);
  endtask

  task automatic drive0(input logic v, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [CW-1:0] c);
    req0_valid = v; req0_in1 = a; req0_in2 = b; req0_ctrl = c;
  endtask

  task automatic drive1(input logic v, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [CW-1:0] c);
    req1_valid = v; req1_in1 = a; req1_in2 = b; req1_ctrl = c;
  endtask

  // Wait (bounded) until every queued response has been compared.
  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
    check("drain_pending", sb.size(), 0);
  endtask

  // Scoreboard: compare each response at the cycle it is handed over.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", rsp_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id",   rsp_id,   e.id);
        check("rsp_data", rsp_data, e.data);
        check("rsp_flag", rsp_flag, e.flag);
        check("ccr",      ccr,      e.flag);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

`ifdef ALU_SHARE_FIXED_PRIO_EN
  logic exp_ids [3] = '{1'b0, 1'b0, 1'b0};
`else
  logic exp_ids [3] = '{1'b0, 1'b1, 1'b0};
`endif

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    drive0(1'b0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0);

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_alu_in1",   alu_in1,   0);
    check("rst_alu_in2",   alu_in2,   0);
    check("rst_alu_ctrl",  alu_ctrl,  0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data",  rsp_data,  0);
    check("rst_ccr",       ccr,       0);
    check("rst_busy",      busy,      0);
    tick();
    tick();
    rst_n = 1'b1;

    // ---------------- single request, requester 0 ----------------
    drive0(1'b1, 16'd255, 16'd1, 3'b000);
    push_exp(1'b0, 16'd255, 16'd1, 3'b000);
    @(negedge clk);
    check("t1_req0_ready", req0_ready, 1);
    check("t1_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_alu_in1",     alu_in1,    255);
    check("t1_alu_ctrl",    alu_ctrl,   0);
    check("t1_ready_exec",  req0_ready, 0);
    check("t1_busy",        busy,       1);
    check("t1_valid_early", rsp_valid,  0);
    tick();
    @(negedge clk);
    check("t1_rsp_valid_lat2", rsp_valid, 1);
    tick();
    @(negedge clk);
    check("t1_idle_busy",  busy,      0);
    check("t1_idle_valid", rsp_valid, 0);
    check("t1_ccr_hold",   ccr,       0);
    tick();

    // ---------------- single request, requester 1 ----------------
    drive1(1'b1, 16'h1234, 16'h00FF, 3'b001);
    push_exp(1'b1, 16'h1234, 16'h00FF, 3'b001);
    @(negedge clk);
    check("t2_req1_ready", req1_ready, 1);
    check("t2_req0_ready", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    wait_drain(8);

    // ---------------- simultaneous requests ----------------
    drive0(1'b1, 16'h0001, 16'hFFFF, 3'b000);
    drive1(1'b1, 16'h00F0, 16'h0F0F, 3'b001);
    for (int c = 0; c < 5; c++) begin
      if (c % 2 == 0) begin
        if (exp_ids[c/2]) push_exp(1'b1, 16'h00F0, 16'h0F0F, 3'b001);
        else              push_exp(1'b0, 16'h0001, 16'hFFFF, 3'b000);
      end
      @(negedge clk);
      check("t3_req0_ready", req0_ready, (c % 2 == 0) && !exp_ids[c/2]);
      check("t3_req1_ready", req1_ready, (c % 2 == 0) &&  exp_ids[c/2]);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain(10);

    // ---------------- backpressure ----------------
    rsp_ready = 1'b0;
    drive0(1'b1, 16'h7FFF, 16'h0001, 3'b000);
    push_exp(1'b0, 16'h7FFF, 16'h0001, 3'b000);
    @(negedge clk);
    check("t4_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    drive1(1'b1, 16'h00FF, 16'h0F0F, 3'b001);
    push_exp(1'b1, 16'h00FF, 16'h0F0F, 3'b001);
    @(negedge clk);
    check("t4_req1_exec", req1_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", rsp_valid,  1);
      check("t4_hold_data",  rsp_data,   16'h8000);
      check("t4_hold_flag",  rsp_flag,   3'b100);
      check("t4_hold_id",    rsp_id,     0);
      check("t4_hold_r0",    req0_ready, 0);
      check("t4_hold_r1",    req1_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_req1_same_cycle", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    check("t4_exec_busy",  busy,      1);
    check("t4_exec_valid", rsp_valid, 0);
    check("t4_exec_in1",   alu_in1,   16'h00FF);
    tick();
    wait_drain(8);

    // ---------------- reset during EXEC ----------------
    drive1(1'b1, 16'h0003, 16'h0004, 3'b000);
    @(negedge clk);
    check("t5_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_alu_in1",   alu_in1,   0);
    check("t5_alu_in2",   alu_in2,   0);
    check("t5_alu_ctrl",  alu_ctrl,  0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_rsp_id",    rsp_id,    0);
    check("t5_rsp_data",  rsp_data,  0);
    check("t5_rsp_flag",  rsp_flag,  0);
    check("t5_ccr",       ccr,       0);
    check("t5_busy",      busy,      0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_rsp",  rsp_valid, 0);
      check("t5_no_busy", busy,      0);
      tick();
    end
    drive0(1'b1, 16'h00AA, 16'h0055, 3'b001);
    drive1(1'b1, 16'h0001, 16'h0001, 3'b000);
    push_exp(1'b0, 16'h00AA, 16'h0055, 3'b001);
    @(negedge clk);
    check("t5_first_r0", req0_ready, 1);
    check("t5_first_r1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain(8);

`ifdef ALU_SHARE_FIXED_PRIO_EN
    // ---------------- fixed priority, both always valid ----------------
    drive0(1'b1, 16'h0010, 16'h0020, 3'b000);
    drive1(1'b1, 16'h0F00, 16'h00F0, 3'b001);
    for (int op = 0; op < 4; op++) begin
      push_exp(1'b0, 16'h0010, 16'h0020, 3'b000);
      @(negedge clk);
      check("t6_fp_r0", req0_ready, 1);
      check("t6_fp_r1", req1_ready, 0);
      tick();
      if (op < 3) tick();
    end
    req0_valid = 1'b0;
    tick();
    push_exp(1'b1, 16'h0F00, 16'h00F0, 3'b001);
    @(negedge clk);
    check("t6_fp_r1_after", req1_ready, 1);
    check("t6_fp_r0_after", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    wait_drain(8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 16-bit ALU between two requesters, e.g. the main execute slot and a secondary address/branch-compare unit.
- Arbitrates requests, registers the granted operands and control onto the ALU input ports, and captures the ALU result and flags one cycle later.
- Returns the captured result to the granted requester over a valid/ready response channel and keeps a condition-code register (CCR) holding the latest flags.

Parameters:
- DATA_W, 16, operand/result width
- CTRL_W, 3, ALU control width
- FLAG_W, 3, ALU flag width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request from requester 0 / 1
- req0_ready / req1_ready  out  1  requester 0 / 1 accepted this cycle
- req0_in1, req0_in2 / req1_in1, req1_in2  in  DATA_W  operands
- req0_ctrl / req1_ctrl  in  CTRL_W  ALU control
- alu_in1, alu_in2  out  DATA_W  registered operands to the ALU
- alu_ctrl  out  CTRL_W  registered control to the ALU
- alu_out  in  DATA_W  combinational ALU result
- alu_flag  in  FLAG_W  combinational ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that owns the response
- rsp_data  out  DATA_W  captured result
- rsp_flag  out  FLAG_W  captured flags
- ccr  out  FLAG_W  flags of the most recently completed operation
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, last_grant=1
  - alu_in1, alu_in2, alu_ctrl, rsp_valid, rsp_id, rsp_data, rsp_flag, ccr, busy all 0
  - An in-flight operation is dropped and no response is produced.
- States: IDLE, EXEC, RESP.
- Accept window:
  - "Accept window" = state==IDLE, or state==RESP with rsp_ready=1.
  - reqN_ready is combinational: asserted only for the granted requester, only inside the accept window.
  - At most one ready is high per cycle.
- Arbitration (round-robin):
  - If only one request is valid, it wins.
  - If both are valid, the winner is the requester != last_grant.
  - last_grant updates on accept.
- Accept edge: load alu_in1/alu_in2/alu_ctrl from the winner, record the id, go to EXEC.
- EXEC (exactly one cycle):
  - At the next edge, capture alu_out→rsp_data, alu_flag→rsp_flag and ccr.
  - Set rsp_valid=1 and go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1 with no accepted request: rsp_valid→0, go to IDLE.
  - On rsp_ready=1 with an accepted request: rsp_valid→0, go to EXEC.
- Latency and throughput:
  - Accept→rsp_valid is 2 edges.
  - Sustained throughput is one op per 2 cycles when rsp_ready is held high.
- ALU inputs hold their last values while in IDLE and RESP; they are not cleared.
- ccr changes only on EXEC→RESP capture.
- Requesters must hold valid/operands until ready; if valid is deasserted without ready, nothing happens.
- reqN_ready never depends on rsp_valid of the same cycle except through the accept window above.

Optional Feature:
- Macro: ALU_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both are valid; last_grant is still updated but ignored.
- Undefined: round-robin as specified above.

Test Plan:
- Bench uses an ALU stub: out=in1+in2 when ctrl=000, else in1&in2; flag={out[15], carry, out==0}.
- Single request: req0 (255, 1, 000) with rsp_ready=1.
  - -> req0_ready for 1 cycle; alu_in1=255 on the next cycle.
  - -> rsp_valid=1 two edges after accept, with rsp_id=0, rsp_data=256, ccr=3'b000.
- Simultaneous requests: req0 (0x0001, 0xFFFF, 000) and req1 (0x00F0, 0x0F0F, 001) held valid, rsp_ready=1.
  - -> req0 granted first: rsp 0x0000, flag 3'b011.
  - -> then req1: rsp 0x0000, rsp_id=1.
  - -> then req0 again if still valid, confirming alternation.
- Backpressure: rsp_ready=0 for 5 cycles after a response.
  - -> rsp_data/rsp_flag/rsp_id stable; both ready=0.
  - -> raising rsp_ready with req1 valid gives same-cycle req1_ready and EXEC next cycle.
- Reset mid-operation: assert rst_n=0 during EXEC.
  - -> all outputs 0 immediately, no response after release.
  - -> first grant after reset goes to req0.
- With ALU_SHARE_FIXED_PRIO_EN: both requesters continuously valid for 4 ops.
  - -> all 4 responses have rsp_id=0; req1 is granted only after req0_valid drops.
